// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: majority-vote bit sampling, runtime parity/stop config,
// false-start/parity/framing/break detection and a registered-head output FIFO.
module uart_rx_ovs #(
    parameter int unsigned DATA_WDTH  = 8,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               CLKip,
    input  logic                               rst,
    input  logic                               RXi,
    input  logic [15:0]                        DIVi,
    input  logic [1:0]                         PAR_MODEi,
    input  logic                               STOP2i,
    input  logic                               READYi,
    output logic                               VALIDo,
    output logic [DATA_WDTH-1:0]               DATAo,
    output logic                               PERRo,
    output logic                               FERRo,
    output logic                               BRKo,
    output logic                               OVERRUNo,
    output logic                               BUSYo,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    LEVELo
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_WDTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_WDTH + 3;
    localparam logic [SW-1:0] SubS0   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SubS1   = SW'(OVS / 2);
    localparam logic [SW-1:0] SubS2   = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] SubEnd  = SW'(OVS - 1);
    localparam logic [BW-1:0] LastBit = BW'(DATA_WDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrkwait} state_t;

    state_t                 state_q, state_d;
    logic                   rx_s1, rx_s2, rx_prev;
    logic [15:0]            div_q;
    logic [1:0]             par_q;
    logic                   stop2_q;
    logic [15:0]            div_cnt_q, div_cnt_d;
    logic [SW-1:0]          sub_q, sub_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_WDTH-1:0]   shift_q, shift_d;
    logic                   par_acc_q, par_acc_d;
    logic                   zero_q, zero_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   wr_en;
    logic [EW-1:0]          wr_data;

    logic [15:0] div_eff;
    logic        tick, fall, maj, decide, bit_end, par_en, ferr_now, brk_now;

    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick    = (div_cnt_q == div_eff - 16'd1);
    assign fall    = rx_prev & ~rx_s2;
    // samp_q holds the first two votes; the third is the live synchronised sample
    assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s2) | (samp_q[0] & rx_s2);
    assign decide  = tick && (sub_q == SubS2);
    assign bit_end = tick && (sub_q == SubEnd);
    assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);
    assign ferr_now = ferr_q | ~maj;
    assign brk_now  = stop_idx_q ? brk_q : (zero_q & ~maj);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        zero_d     = zero_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        wr_en      = 1'b0;
        wr_data    = {brk_now, ferr_now | brk_now, perr_q, shift_q};

        if (state_q inside {StStart, StData, StParity, StStop}) begin
            div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
            if (tick) begin
                sub_d = (sub_q == SubEnd) ? '0 : sub_q + SW'(1);
                if (sub_q == SubS0 || sub_q == SubS1) samp_d = {samp_q[0], rx_s2};
            end
        end

        unique case (state_q)
            StIdle: begin
                div_cnt_d = '0;
                sub_d     = '0;
                if (fall) begin
                    state_d    = StStart;
                    bit_d      = '0;
                    stop_idx_d = 1'b0;
                    shift_d    = '0;
                    par_acc_d  = 1'b0;
                    zero_d     = 1'b1;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    brk_d      = 1'b0;
                end
            end
            StStart: begin
                if (decide && maj) state_d = StIdle;
                else if (bit_end)  state_d = StData;
            end
            StData: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[DATA_WDTH-1:1]};
                    par_acc_d = par_acc_q ^ maj;
                    zero_d    = zero_q & ~maj;
                end
                if (bit_end) begin
                    if (bit_q == LastBit) begin
                        bit_d   = '0;
                        state_d = par_en ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    perr_d = ((par_acc_q ^ maj) != (par_q == 2'b10));
                    zero_d = zero_q & ~maj;
                end
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (decide) begin
                    if (stop_idx_q || !stop2_q) begin
                        wr_en   = 1'b1;
                        state_d = brk_now ? StBrkwait : StIdle;
                    end else begin
                        ferr_d = ferr_now;
                        brk_d  = brk_now;
                    end
                end
                if (bit_end) stop_idx_d = 1'b1;
            end
            StBrkwait: begin
                if (rx_s2) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLKip) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            state_q    <= StIdle;
            div_q      <= 16'd1;
            par_q      <= 2'b00;
            stop2_q    <= 1'b0;
            div_cnt_q  <= '0;
            sub_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            zero_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            rx_s1      <= RXi;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            zero_q     <= zero_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            if (state_q == StIdle && fall) begin
                div_q   <= DIVi;
                par_q   <= PAR_MODEi;
                stop2_q <= STOP2i;
            end
        end
    end

    // Output FIFO with registered head; a full FIFO still accepts a write paired with a pop
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [EW-1:0] head_q, head_d;
    logic          valid_q, overrun_q, full, pop, push;

    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign pop     = valid_q & READYi;
    assign push    = wr_en & (~full | pop);
    assign rptr_d  = rptr_q + PW'(pop);
    assign wptr_d  = wptr_q + PW'(push);
    assign count_d = count_q + LW'(push) - LW'(pop);

    always_comb begin
        head_d = mem[rptr_d];
        if (push && rptr_d == wptr_q) head_d = wr_data;
        if (count_d == '0)            head_d = '0;
    end

    always_ff @(posedge CLKip) begin
        if (push) mem[wptr_q] <= wr_data;
    end

    always_ff @(posedge CLKip) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            valid_q   <= (count_d != '0);
            overrun_q <= wr_en & full & ~pop;
        end
    end

    assign VALIDo   = valid_q;
    assign {BRKo, FERRo, PERRo, DATAo} = head_q;
    assign OVERRUNo = overrun_q;
    assign BUSYo    = (state_q != StIdle);
    assign LEVELo   = count_q;

endmodule
